// File: rtl/dcache_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dcache_responder                                                |
// | Purpose  : Direct-mapped, one-word-line, write-through / no-write-allocate |
// |            data cache between the core data port and main memory.          |
// |            Hits answer with one-cycle latency. The registered stall output |
// |            freezes the core across misses and memory write handshakes.     |
// | Ports    : clk, reset (sync, active-high)                                  |
// |            dcache_addr/re/we/din -> dcache_dout, stall   (core side)       |
// |            mem_req_valid/ready/rw/addr/data/mask          (memory request) |
// |            mem_resp_valid/data                            (memory response)|
// | Options  : DCACHE_WBUF_EN - one-entry write buffer with a DRAIN state.     |
// |            When undefined, every write stalls through WR_REQ.              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dcache_responder #(
  parameter int LINES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dcache_addr,
  input  logic        dcache_re,
  input  logic [3:0]  dcache_we,
  input  logic [31:0] dcache_din,
  output logic [31:0] dcache_dout,
  output logic        stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_rw,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_data,
  output logic [3:0]  mem_req_mask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam int IDXW = $clog2(LINES);
  localparam int TAGW = 30 - IDXW;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
`ifdef DCACHE_WBUF_EN
  localparam logic [2:0] S_DRAIN   = 3'd4;
`endif

  logic [2:0]  state_q, state_d;
  logic        stall_q;
  logic [31:0] dout_q, dout_d;
  logic        req_valid_q, req_valid_d;
  logic        req_rw_q, req_rw_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] req_data_q, req_data_d;
  logic [3:0]  req_mask_q, req_mask_d;

`ifdef DCACHE_WBUF_EN
  // Core operation parked while the buffered write drains.
  logic        op_wr_q, op_wr_d;
  logic [31:0] op_addr_q, op_addr_d;
  logic [31:0] op_data_q, op_data_d;
  logic [3:0]  op_mask_q, op_mask_d;
`endif

  logic [LINES-1:0] valid_q;
  logic [TAGW-1:0]  tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  // Single line write port shared by write-hit merge and read fill.
  logic            line_we;
  logic [IDXW-1:0] line_idx;
  logic [TAGW-1:0] line_tag;
  logic [31:0]     line_data;

  logic [IDXW-1:0] cur_idx;
  logic [TAGW-1:0] cur_tag;
  logic            cur_hit;
  logic [31:0]     cur_line;
  logic [31:0]     merged;
  logic [31:0]     word_addr;
  logic            accept;
  logic            is_wr;
  logic [1:0]      unused_addr_lsb;

  assign cur_idx         = dcache_addr[2 +: IDXW];
  assign cur_tag         = dcache_addr[31 -: TAGW];
  assign cur_hit         = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);
  assign cur_line        = data_q[cur_idx];
  assign word_addr       = {dcache_addr[31:2], 2'b00};
  assign accept          = (state_q == S_IDLE) && !stall_q;
  assign is_wr           = |dcache_we;
  assign unused_addr_lsb = dcache_addr[1:0];

  always_comb begin
    merged = cur_line;
    for (int b = 0; b < 4; b++) begin
      if (dcache_we[b]) merged[8*b +: 8] = dcache_din[8*b +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    dout_d      = dout_q;
    req_valid_d = req_valid_q;
    req_rw_d    = req_rw_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    req_mask_d  = req_mask_q;
    line_we     = 1'b0;
    line_idx    = cur_idx;
    line_tag    = cur_tag;
    line_data   = merged;
`ifdef DCACHE_WBUF_EN
    op_wr_d     = op_wr_q;
    op_addr_d   = op_addr_q;
    op_data_d   = op_data_q;
    op_mask_d   = op_mask_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef DCACHE_WBUF_EN
        // Background drain of the buffered write.
        if (req_valid_q && mem_req_ready) req_valid_d = 1'b0;
`endif
        if (accept) begin
          if (is_wr) begin
            line_we = cur_hit;
`ifdef DCACHE_WBUF_EN
            // Buffer still occupied after this edge: park the write.
            if (req_valid_q && !mem_req_ready) begin
              state_d   = S_DRAIN;
              op_wr_d   = 1'b1;
              op_addr_d = word_addr;
              op_data_d = dcache_din;
              op_mask_d = dcache_we;
            end else begin
              req_valid_d = 1'b1;
              req_rw_d    = 1'b1;
              req_addr_d  = word_addr;
              req_data_d  = dcache_din;
              req_mask_d  = dcache_we;
            end
`else
            req_valid_d = 1'b1;
            req_rw_d    = 1'b1;
            req_addr_d  = word_addr;
            req_data_d  = dcache_din;
            req_mask_d  = dcache_we;
            state_d     = S_WR_REQ;
`endif
          end else if (dcache_re) begin
            if (cur_hit) begin
              dout_d = cur_line;
`ifdef DCACHE_WBUF_EN
            end else if (req_valid_q && !mem_req_ready) begin
              // Keep memory ordered: the buffered write goes out first.
              state_d   = S_DRAIN;
              op_wr_d   = 1'b0;
              op_addr_d = word_addr;
              op_data_d = 32'h0;
              op_mask_d = 4'h0;
`endif
            end else begin
              req_valid_d = 1'b1;
              req_rw_d    = 1'b0;
              req_addr_d  = word_addr;
              req_data_d  = 32'h0;
              req_mask_d  = 4'h0;
              state_d     = S_RD_REQ;
            end
          end
        end
      end
      S_RD_REQ: begin
        if (mem_req_ready) begin
          req_valid_d = 1'b0;
          state_d     = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        // req_addr_q still holds the miss address and locates the fill.
        if (mem_resp_valid) begin
          line_we   = 1'b1;
          line_idx  = req_addr_q[2 +: IDXW];
          line_tag  = req_addr_q[31 -: TAGW];
          line_data = mem_resp_data;
          dout_d    = mem_resp_data;
          state_d   = S_IDLE;
        end
      end
      S_WR_REQ: begin
        if (mem_req_ready) begin
          req_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
`ifdef DCACHE_WBUF_EN
      S_DRAIN: begin
        if (mem_req_ready) begin
          req_valid_d = 1'b1;
          req_rw_d    = op_wr_q;
          req_addr_d  = op_addr_q;
          req_data_d  = op_data_q;
          req_mask_d  = op_mask_q;
          state_d     = op_wr_q ? S_IDLE : S_RD_REQ;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      stall_q     <= 1'b0;
      dout_q      <= 32'h0;
      req_valid_q <= 1'b0;
      req_rw_q    <= 1'b0;
      req_addr_q  <= 32'h0;
      req_data_q  <= 32'h0;
      req_mask_q  <= 4'h0;
      valid_q     <= '0;
`ifdef DCACHE_WBUF_EN
      op_wr_q     <= 1'b0;
      op_addr_q   <= 32'h0;
      op_data_q   <= 32'h0;
      op_mask_q   <= 4'h0;
`endif
    end else begin
      state_q     <= state_d;
      // Derived from next state only, so stall never depends on core inputs combinationally.
      stall_q     <= (state_d != S_IDLE);
      dout_q      <= dout_d;
      req_valid_q <= req_valid_d;
      req_rw_q    <= req_rw_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      req_mask_q  <= req_mask_d;
      if (line_we) valid_q[line_idx] <= 1'b1;
`ifdef DCACHE_WBUF_EN
      op_wr_q     <= op_wr_d;
      op_addr_q   <= op_addr_d;
      op_data_q   <= op_data_d;
      op_mask_q   <= op_mask_d;
`endif
    end
  end

  // Tag/data need no reset: valid bits gate every use.
  generate
    for (genvar i = 0; i < LINES; i++) begin : g_lines
      always_ff @(posedge clk) begin
        if (line_we && (line_idx == IDXW'(i))) begin
          tag_q[i]  <= line_tag;
          data_q[i] <= line_data;
        end
      end
    end
  endgenerate

  assign dcache_dout   = dout_q;
  assign stall         = stall_q;
  assign mem_req_valid = req_valid_q;
  assign mem_req_rw    = req_rw_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_data  = req_data_q;
  assign mem_req_mask  = req_mask_q;

endmodule
`default_nettype wire

// File: tb/tb_dcache_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dcache_responder                                             |
// | Purpose  : Self-checking bench for dcache_responder. Expected read data    |
// |            and expected memory requests are queued when stimulus is driven |
// |            and popped when the DUT returns data / issues a request.        |
// | Options  : DCACHE_WBUF_EN - also exercises the write buffer.               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_dcache_responder;

`ifdef DCACHE_WBUF_EN
  localparam int WR_STALL = 0;
`else
  localparam int WR_STALL = 1;
`endif
  localparam int LAT = 3;

  logic        clk;
  logic        reset;
  logic [31:0] dcache_addr;
  logic        dcache_re;
  logic [3:0]  dcache_we;
  logic [31:0] dcache_din;
  logic [31:0] dcache_dout;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_rw;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_mask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  dcache_responder #(.LINES(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .dcache_addr   (dcache_addr),
    .dcache_re     (dcache_re),
    .dcache_we     (dcache_we),
    .dcache_din    (dcache_din),
    .dcache_dout   (dcache_dout),
    .stall         (stall),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_rw    (mem_req_rw),
    .mem_req_addr  (mem_req_addr),
    .mem_req_data  (mem_req_data),
    .mem_req_mask  (mem_req_mask),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } req_t;

  logic [31:0] exp_q[$];      // expected dcache_dout per read
  req_t        exp_req[$];    // expected memory requests, in order
  logic        armed = 1'b0;  // a read is waiting for its result

  // ---------------- memory model ----------------
  logic [31:0] memory [logic [31:0]];
  int          ready_hold = 0;
  int          resp_ctr   = 0;
  bit          resp_pend  = 0;
  logic [31:0] resp_dat   = 32'h0;

  function automatic logic [31:0] mrd(input logic [31:0] a);
    return memory.exists(a) ? memory[a] : 32'h0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      resp_pend = 0;
    end else if (mem_req_valid && mem_req_ready) begin
      if (exp_req.size() == 0) begin
        check("mreq_unexpected", mem_req_addr, 32'hFFFF_FFFF);
      end else begin
        req_t e;
        e = exp_req.pop_front();
        check("mreq_rw", {31'h0, mem_req_rw}, {31'h0, e.rw});
        check("mreq_addr", mem_req_addr, e.addr);
        check("mreq_mask", {28'h0, mem_req_mask}, {28'h0, e.mask});
        if (e.rw) check("mreq_data", mem_req_data, e.data);
      end
      if (mem_req_rw) begin
        logic [31:0] w;
        w = mrd(mem_req_addr);
        for (int b = 0; b < 4; b++)
          if (mem_req_mask[b]) w[8*b +: 8] = mem_req_data[8*b +: 8];
        memory[mem_req_addr] = w;
      end else begin
        resp_pend = 1;
        resp_ctr  = LAT;
        resp_dat  = mrd(mem_req_addr);
      end
    end
    #1;
    mem_resp_valid = 1'b0;
    if (resp_pend) begin
      resp_ctr--;
      if (resp_ctr == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = resp_dat;
        resp_pend      = 0;
      end
    end
    if (ready_hold > 0) begin
      mem_req_ready = 1'b0;
      ready_hold--;
    end else begin
      mem_req_ready = 1'b1;
    end
  end

  // ---------------- read-result monitor ----------------
  always @(negedge clk) begin
    if (armed && !stall) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected", dcache_dout, 32'hFFFF_FFFF);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("rd_data", dcache_dout, e);
      end
      armed = 1'b0;
    end
  end

  // ---------------- core-side driver ----------------
  task automatic expect_req(input logic rw, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] m);
    req_t e;
    e.rw = rw; e.addr = a; e.data = d; e.mask = m;
    exp_req.push_back(e);
  endtask

  // Called at a negedge with stall low; returns at the following negedge.
  task automatic issue(input logic re, input logic [3:0] we, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_dout);
    dcache_addr = a;
    dcache_re   = re;
    dcache_we   = we;
    dcache_din  = d;
    if (re && we == 4'h0) exp_q.push_back(exp_dout);
    @(posedge clk);
    #1;
    if (re && we == 4'h0) armed = 1'b1;
    @(negedge clk);
    dcache_re = 1'b0;
    dcache_we = 4'h0;
  endtask

  task automatic wait_stall(input int exp_n, input string tag);
    int n = 0;
    while (stall && n < 64) begin
      n++;
      @(negedge clk);
    end
    check(tag, 32'(n), 32'(exp_n));
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input bit miss);
    if (miss) expect_req(1'b0, a, 32'h0, 4'h0);
    issue(1'b1, 4'h0, a, 32'h0, exp);
    wait_stall(miss ? 1 + LAT : 0, miss ? "rd_miss_stall" : "rd_hit_stall");
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
    expect_req(1'b1, a, d, we);
    issue(1'b0, we, a, d, 32'h0);
    wait_stall(WR_STALL, "wr_stall");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    memory[32'h000] = 32'hA0A0_A0A0;
    memory[32'h040] = 32'hB0B0_B0B0;
    memory[32'h100] = 32'hDEAD_BEEF;
    memory[32'h104] = 32'h0104_0104;
    memory[32'h108] = 32'h0108_0108;
    memory[32'h200] = 32'h1122_3344;
    memory[32'h400] = 32'h5566_7788;
    reset = 1'b1; dcache_addr = 32'h0; dcache_re = 1'b0; dcache_we = 4'h0; dcache_din = 32'h0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_mvalid", {31'h0, mem_req_valid}, 32'h0);
    check("rst_dout", dcache_dout, 32'h0);
    check("rst_maddr", mem_req_addr, 32'h0);
    check("rst_mdata", mem_req_data, 32'h0);
    check("rst_mmask_rw", {27'h0, mem_req_rw, mem_req_mask}, 32'h0);

    // Cold miss then hit.
    do_read(32'h100, 32'hDEAD_BEEF, 1);
    do_read(32'h100, 32'hDEAD_BEEF, 0);

    // Byte-merge on write hit.
    do_read(32'h200, 32'h1122_3344, 1);
    do_write(32'h200, 4'b0010, 32'h0000_AA00);
    check("wr_dout_hold", dcache_dout, 32'h1122_3344);
    do_read(32'h200, 32'h1122_AA44, 0);

    // No write allocate.
    do_write(32'h300, 4'b1111, 32'h1234_5678);
    do_read(32'h300, 32'h1234_5678, 1);

    // Ready held low during RD_REQ.
    ready_hold = 5;
    expect_req(1'b0, 32'h400, 32'h0, 4'h0);
    issue(1'b1, 4'h0, 32'h400, 32'h0, 32'h5566_7788);
    for (int k = 0; k < 5; k++) begin
      check("hold_stall", {31'h0, stall}, 32'h1);
      check("hold_valid", {31'h0, mem_req_valid}, 32'h1);
      check("hold_addr", mem_req_addr, 32'h400);
      check("hold_rw_mask", {27'h0, mem_req_rw, mem_req_mask}, 32'h0);
      @(negedge clk);
    end
    wait_stall(1 + LAT, "hold_rest_stall");

    // Alias conflict: both map to line 0.
    for (int k = 0; k < 2; k++) begin
      do_read(32'h000, 32'hA0A0_A0A0, 1);
      do_read(32'h040, 32'hB0B0_B0B0, 1);
    end
    do_read(32'h040, 32'hB0B0_B0B0, 0);

`ifdef DCACHE_WBUF_EN
    // Back-to-back writes with ready low: first free, second waits for the first.
    ready_hold = 6;
    expect_req(1'b1, 32'h500, 32'h5050_5050, 4'hF);
    issue(1'b0, 4'hF, 32'h500, 32'h5050_5050, 32'h0);
    wait_stall(0, "wb_first_stall");
    expect_req(1'b1, 32'h504, 32'h5040_5040, 4'hF);
    issue(1'b0, 4'hF, 32'h504, 32'h5040_5040, 32'h0);
    wait_stall(6, "wb_second_stall");
    repeat (2) @(negedge clk);

    // Read miss behind a pending buffered write.
    ready_hold = 3;
    expect_req(1'b1, 32'h600, 32'h6060_6060, 4'hF);
    issue(1'b0, 4'hF, 32'h600, 32'h6060_6060, 32'h0);
    wait_stall(0, "wb_w_stall");
    expect_req(1'b0, 32'h100, 32'h0, 4'h0);
    issue(1'b1, 4'h0, 32'h100, 32'h0, 32'hDEAD_BEEF);
    wait_stall(7, "wb_drain_rd_stall");
`endif

    // Reset in RD_WAIT abandons the miss and invalidates every line.
    do_read(32'h104, 32'h0104_0104, 1);
    do_read(32'h104, 32'h0104_0104, 0);
    expect_req(1'b0, 32'h108, 32'h0, 4'h0);
    issue(1'b1, 4'h0, 32'h108, 32'h0, 32'h0108_0108);
    @(negedge clk);
    check("rw_stall_before_rst", {31'h0, stall}, 32'h1);
    armed = 1'b0;
    exp_q.delete();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_stall", {31'h0, stall}, 32'h0);
    check("midrst_mvalid", {31'h0, mem_req_valid}, 32'h0);
    check("midrst_dout", dcache_dout, 32'h0);
    do_read(32'h104, 32'h0104_0104, 1);
    do_read(32'h040, 32'hB0B0_B0B0, 1);

    repeat (10) @(negedge clk);
    check("rd_queue_empty", 32'(exp_q.size()), 32'h0);
    check("mreq_queue_empty", 32'(exp_req.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dcache_responder.md
# dcache_responder

Direct-mapped, one-word-line, write-through/no-write-allocate data cache that serves the core's `dcache_*` port and drives its `stall` input. It sits between the core's data port and a main-memory request/response port. It answers hits with the core's synchronous one-cycle read latency and holds `stall` high across misses and memory write handshakes.

## Interface
- `LINES`, 16: number of lines; power of two, 2..256. `IDXW = log2(LINES)`.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `dcache_addr` in 32: byte address; bits [1:0] ignored.
- `dcache_re` in 1: read request.
- `dcache_we` in 4: byte write enables; bit i writes `dcache_din[8i+7:8i]`.
- `dcache_din` in 32: store data.
- `dcache_dout` out 32: read data.
- `stall` out 1: core freeze; registered.
- `mem_req_valid` out 1: memory request valid.
- `mem_req_ready` in 1: memory accepts the request this cycle.
- `mem_req_rw` out 1: 1 = write, 0 = read.
- `mem_req_addr` out 32: word-aligned address, bits [1:0] = 0.
- `mem_req_data` out 32: write data.
- `mem_req_mask` out 4: write byte mask; 0 for reads.
- `mem_resp_valid` in 1: read data valid, one cycle per read, in request order.
- `mem_resp_data` in 32: read data.

## Operation
- Address split: index = `addr[2+IDXW-1:2]`, tag = `addr[31:2+IDXW]`. Storage: per line a valid bit, tag, and 32-bit data word, all in flops.
- Requests are accepted only in IDLE with `stall`=0. `dcache_re` and nonzero `dcache_we` in the same cycle: write wins, and the read is ignored. All inputs are ignored while `stall`=1.
- States:
  - IDLE
  - RD_REQ: `mem_req_valid`=1, rw=0.
  - RD_WAIT
  - WR_REQ: `mem_req_valid`=1, rw=1.
  - DRAIN: write-buffer flush; exists only when the write buffer is compiled in.
- Read hit: `dcache_dout` = line data on the next cycle; state stays IDLE.
- Read miss: next state RD_REQ. RD_REQ goes to RD_WAIT on `mem_req_ready`. RD_WAIT goes to IDLE on `mem_resp_valid`.
  - On `mem_resp_valid`: the line is filled with valid=1, the new tag, and `mem_resp_data`, and `dcache_dout` takes `mem_resp_data`.
- Write: on a hit, only the enabled bytes of the line are merged. On a miss, the line is unchanged. Next state WR_REQ with addr, din and mask latched; WR_REQ goes to IDLE on `mem_req_ready`.
- `mem_req_*` hold stable while valid and not ready.
- `stall` is 1 in every state except IDLE.
- `dcache_dout` holds its last value except on a hit or fill.
- Reset:
  - State IDLE; all valid bits = 0.
  - `stall`=0, `mem_req_valid`=0, `dcache_dout`=0, `mem_req_addr/data/mask`=0, `mem_req_rw`=0.
  - Reset mid-miss abandons the transaction. Main memory is reset on the same `reset`, so no stale response arrives.

## Timing
- Request in cycle N (stall=0) leads to a response in cycle N+1.
  - Hit: `stall`=0 in N+1 and `dcache_dout` is valid in N+1.
  - Miss or write: `stall`=1 from N+1. In the first cycle `stall` returns to 0, `dcache_dout` holds the read data.
- Read miss stall duration: 1 cycle + cycles waiting for ready + response latency. With `mem_req_ready` tied high and response latency L ≥ 1, stall is high for 1+L cycles.
- `stall` is never a combinational function of core inputs (no loop through the core's `dcache_re` gating).
- Fill and `mem_resp_valid` on the same edge as the transition to IDLE: the core sees the data with `stall`=0 in the next cycle.

## Configuration
- `DCACHE_WBUF_EN` defined: one-entry write buffer.
  - A write with the buffer empty updates the line on a hit, loads the buffer, and does not stall (response as for a hit). The buffer drives WR_REQ-style requests from IDLE in the background.
  - A write with the buffer full goes to DRAIN (stall) until ready, then loads the buffer and returns to IDLE.
  - A read hit never waits for the buffer.
  - A read miss with the buffer full goes DRAIN, then RD_REQ, so memory stays in order.
  - Reset empties the buffer.
- Undefined: no buffer, no DRAIN state; every write stalls through WR_REQ as above.

## Test plan
- Reset, then read 0x100 (cold miss), with memory returning 0xDEADBEEF at latency 3 and ready high. Required: stall high 4 cycles, then `dcache_dout`=0xDEADBEEF with stall=0, exactly one read request at 0x100. Second read of 0x100: hit, no stall, no memory request.
- Fill 0x200 with 0x11223344, then write `dcache_we`=4'b0010 with din=0x0000AA00. Required: memory write at 0x200 with mask 0010; a later read hit returns 0x1122AA44.
- Write to uncached 0x300, then read 0x300. Required: line not allocated by the write; read misses and issues a read after the write request.
- Hold `mem_req_ready` low 5 cycles during RD_REQ. Required: `mem_req_*` stable and stall held throughout; correct fill afterward.
- Alias conflict with `LINES`=16: 0x000 and 0x040 alternate reads. Required: every access misses and evicts the other.
- `DCACHE_WBUF_EN`: two back-to-back writes with ready low. Required: the first write does not stall; the second stalls until the first is accepted. Assert `reset` mid-RD_WAIT: stall=0, mem_req_valid=0 and all lines invalid on the next cycle.
